mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares one external memory port between the instruction-fetch side and the data-access side of the 5-stage RV32I core. Each requester keeps its own request/ready-style handshake; the arbiter serialises them onto a single registered bus transaction. It sits between the core's fetch and memory-access stages and the memory or cache interface. Data side has priority, with an optional anti-starvation guard for fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending (used only with ARB_STARVE_GUARD_EN); legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- ireq  in  1  fetch request; held until iready_n is sampled low.
- iaddr  in  32  fetch address; stable while ireq is high.
- iready_n  out  1  active-low fetch completion, one cycle.
- irdata  out  32  fetch data, valid when iready_n is 0.
- dreq  in  1  data request; held until dready_n is sampled low.
- dwrite  in  1  1 = store, 0 = load.
- dsize  in  2  00 byte, 01 half, 10 word.
- daddr  in  32  data address.
- dwdata  in  32  store data.
- dready_n  out  1  active-low data completion, one cycle.
- drdata  out  32  load data, valid when dready_n is 0.
- breq  out  1  bus request, registered.
- bwrite  out  1  bus write strobe, registered.
- bsize  out  2  bus size, registered; fetch always drives 10.
- baddr  out  32  bus address, registered.
- bwdata  out  32  bus write data, registered; 0 for fetch and for loads.
- brdata  in  32  bus read data.
- bready_n  in  1  active-low bus completion.
- bbusy  in  1  bus cannot accept a new transaction.

## Operation
- States:
  - IDLE: no transaction in flight.
  - IGNT: fetch transaction in flight.
  - DGNT: data transaction in flight.
- IDLE, leaving the state:
  - Requires bbusy = 0 and at least one request present.
  - dreq = 1 goes to DGNT; otherwise ireq = 1 goes to IGNT.
  - With ARB_STARVE_GUARD_EN and the starve count = STARVE_LIMIT, ireq wins instead.
- IDLE with bbusy = 1: stay in IDLE and issue nothing.
- On a grant: register the winner's address, size, write and wdata onto the bus; breq = 1.
- IGNT or DGNT while bready_n = 1: hold state and hold all bus outputs.
- IGNT or DGNT when bready_n = 0:
  - Drive the winner's ready_n low in the same cycle.
  - Pass brdata combinationally to the winner's rdata.
  - Next state is always IDLE; breq = 0 the next cycle.
- iready_n and dready_n are never low in the same cycle.
- The loser's ready_n stays 1.
- irdata and drdata are 0 whenever the matching ready_n is 1.
- bready_n = 0 while in IDLE is ignored.
- A requester that drops its request while granted does not abort the transaction. The transaction completes and ready_n still pulses.
- Reset:
  - State returns to IDLE.
  - breq, bwrite, bsize, baddr and bwdata are all 0.
  - iready_n and dready_n are 1; the starve count is 0.
  - Reset asserted mid-transaction abandons the transaction with no ready pulse; breq is 0 after that edge.

## Timing
- Request at cycle N in IDLE with bbusy = 0: breq is high from cycle N+1.
- Completion is the first cycle ≥ N+1 with bready_n = 0. ready_n is low in that same cycle.
- Minimum latency from request to ready is 1 cycle (bready_n low at N+1).
- A transaction occupies at least 2 cycles: grant, then IDLE bubble.
- Back-to-back throughput is one transaction per (k+1) cycles, where k ≥ 1 is the bus latency.
- A request that is still high in the cycle after its own ready pulse is treated as a new request.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit starve counter increments on each DGNT grant made while ireq = 1.
  - The counter saturates at STARVE_LIMIT.
  - At STARVE_LIMIT, the next IDLE arbitration with ireq = 1 grants fetch.
  - The counter clears on any IGNT grant, or when ireq = 0 in IDLE.
- Undefined:
  - No counter logic exists.
  - Data wins every simultaneous request, so fetch can be starved indefinitely.

## Structure
- Shared package or header holds:
  - The state encoding: IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2.
  - The size constants: SZ_BYTE, SZ_HALF, SZ_WORD.
  - The default STARVE_LIMIT.
- Sub-module arb_starve_ctr contains the saturating counter. It has inputs clk, rst, inc, clr and output at_limit, and is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset, then idle: all outputs at their reset values. Drive bready_n = 0 in IDLE: no ready pulse, breq stays 0.
- Fetch of iaddr = 0x0000_0100 with bready_n low 2 cycles after breq:
  - breq = 1, bsize = 10, bwrite = 0.
  - iready_n = 0 for one cycle, irdata = brdata = 0x0000_0013.
- Simultaneous ireq and dreq; data is a store of 0xDEAD_BEEF, dsize = 10, daddr = 0x0000_2000:
  - Data is granted first, with bwdata = 0xDEAD_BEEF.
  - Fetch is granted after the IDLE bubble.
- bbusy = 1 for 3 cycles while dreq = 1: breq stays 0 through those cycles; the grant follows the cycle after bbusy drops.
- Reset asserted while in DGNT with bready_n = 1: no dready_n pulse; breq = 0 the next cycle.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4, dreq and ireq held high continuously: 4 data grants, then 1 fetch grant, and the pattern repeats. Without the macro, every grant goes to data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for mem_port_arbiter.
// The optional fetch anti-starvation guard is enabled with ARB_STARVE_GUARD_EN.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned STARVE_CNT_W     = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Fetches are always word reads with no write data.
  function automatic bus_req_t fetch_req(input logic [ADDR_W-1:0] addr);
    bus_req_t r;
    r.write = 1'b0;
    r.size  = SZ_WORD;
    r.addr  = addr;
    r.wdata = '0;
    return r;
  endfunction

  // Loads carry zero write data so the bus never sees stale store data.
  function automatic bus_req_t data_req(input logic              write,
                                        input logic [1:0]        size,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    bus_req_t r;
    r.write = write;
    r.size  = size;
    r.addr  = addr;
    r.wdata = write ? wdata : '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: saturating count of data grants taken while a fetch waits.
// Exists only when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LIMIT_C)) begin
      r_cnt <= r_cnt + STARVE_CNT_W'(1);
    end
  end

  assign at_limit = (r_cnt == LIMIT_C);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Shares one registered memory bus between fetch and data requesters; data has priority.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iready_n,
  output logic [DATA_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwrite,
  input  logic [1:0]        dsize,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dready_n,
  output logic [DATA_W-1:0] drdata,
  output logic              breq,
  output logic              bwrite,
  output logic [1:0]        bsize,
  output logic [ADDR_W-1:0] baddr,
  output logic [DATA_W-1:0] bwdata,
  input  logic [DATA_W-1:0] brdata,
  input  logic              bready_n,
  input  logic              bbusy
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  arb_state_e r_state;
  bus_req_t   r_bus;
  logic       r_breq;

  logic w_arb_en;
  logic w_fetch_wins;
  logic w_grant_d;
  logic w_grant_i;
  logic w_idone;
  logic w_ddone;

  assign w_arb_en = (r_state == IDLE) && !bbusy && (ireq || dreq);

`ifdef ARB_STARVE_GUARD_EN
  logic w_at_limit;
  logic w_starve_inc;
  logic w_starve_clr;

  assign w_starve_inc = w_grant_d && ireq;
  assign w_starve_clr = w_grant_i || ((r_state == IDLE) && !ireq);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_starve_inc),
    .clr      (w_starve_clr),
    .at_limit (w_at_limit)
  );

  assign w_fetch_wins = ireq && w_at_limit;
`else
  assign w_fetch_wins = 1'b0;
`endif

  // A fetch grant happens whenever arbitration runs and data does not win.
  assign w_grant_d = w_arb_en && dreq && !w_fetch_wins;
  assign w_grant_i = w_arb_en && !w_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_breq  <= 1'b0;
      r_bus   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= DGNT;
            r_breq  <= 1'b1;
            r_bus   <= data_req(dwrite, dsize, daddr, dwdata);
          end else if (w_grant_i) begin
            r_state <= IGNT;
            r_breq  <= 1'b1;
            r_bus   <= fetch_req(iaddr);
          end
        end
        IGNT, DGNT: begin
          if (!bready_n) begin
            r_state <= IDLE;
            r_breq  <= 1'b0;
            r_bus   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_breq  <= 1'b0;
          r_bus   <= '0;
        end
      endcase
    end
  end

  assign breq   = r_breq;
  assign bwrite = r_bus.write;
  assign bsize  = r_bus.size;
  assign baddr  = r_bus.addr;
  assign bwdata = r_bus.wdata;

  // Completion is steered to the current owner in the same cycle as bready_n.
  assign w_idone  = (r_state == IGNT) && !bready_n;
  assign w_ddone  = (r_state == DGNT) && !bready_n;
  assign iready_n = !w_idone;
  assign dready_n = !w_ddone;
  assign irdata   = w_idone ? brdata : '0;
  assign drdata   = w_ddone ? brdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps followed by randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iready_n;
  logic [31:0] irdata;
  logic        dreq;
  logic        dwrite;
  logic [1:0]  dsize;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dready_n;
  logic [31:0] drdata;
  logic        breq;
  logic        bwrite;
  logic [1:0]  bsize;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic [31:0] brdata;
  logic        bready_n;
  logic        bbusy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .iready_n(iready_n), .irdata(irdata),
    .dreq(dreq), .dwrite(dwrite), .dsize(dsize), .daddr(daddr), .dwdata(dwdata),
    .dready_n(dready_n), .drdata(drdata),
    .breq(breq), .bwrite(bwrite), .bsize(bsize), .baddr(baddr), .bwdata(bwdata),
    .brdata(brdata), .bready_n(bready_n), .bbusy(bbusy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: whether a bus transaction is outstanding, whose it is, and its fields.
  bit          m_busy = 1'b0;
  int          m_who = 0;          // 1 = fetch, 2 = data
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0]  m_size = '0;
  logic        m_write = 1'b0;
  int          m_starve = 0;
  bit          i_done = 1'b0;
  bit          d_done = 1'b0;
  logic [31:0] last_irdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already applied at posedge+1; check, advance model, wait.
  task automatic cycle();
    bit done;
    #1;
    chk("breq", 32'(breq), 32'(m_busy));
    if (m_busy) begin
      chk("baddr", baddr, m_addr);
      chk("bsize", 32'(bsize), 32'(m_size));
      chk("bwrite", 32'(bwrite), 32'(m_write));
      chk("bwdata", bwdata, m_wdata);
    end
    done   = m_busy && !bready_n;
    i_done = done && (m_who == 1);
    d_done = done && (m_who == 2);
    chk("iready_n", 32'(iready_n), 32'(!i_done));
    chk("dready_n", 32'(dready_n), 32'(!d_done));
    chk("irdata", irdata, i_done ? brdata : 32'h0);
    chk("drdata", drdata, d_done ? brdata : 32'h0);
    if (i_done) last_irdata = irdata;
    if (rst) begin
      m_busy   = 1'b0;
      m_starve = 0;
    end else if (m_busy) begin
      if (!bready_n) m_busy = 1'b0;
    end else begin
      if (!ireq) m_starve = 0;
      if (!bbusy && (ireq || dreq)) begin
        if (dreq && !(GUARD && ireq && (m_starve >= LIMIT))) begin
          m_who   = 2;
          m_addr  = daddr;
          m_size  = dsize;
          m_write = dwrite;
          m_wdata = dwrite ? dwdata : 32'h0;
          if (ireq && (m_starve < LIMIT)) m_starve++;
        end else begin
          m_who    = 1;
          m_addr   = iaddr;
          m_size   = 2'b10;
          m_write  = 1'b0;
          m_wdata  = 32'h0;
          m_starve = 0;
        end
        m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] seq[$];
    bit ipend;
    bit dpend;
    rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwrite = 1'b0; dsize = SZ_BYTE;
    iaddr = '0; daddr = '0; dwdata = '0; brdata = '0; bready_n = 1'b1; bbusy = 1'b0;
    @(posedge clk);
    #1;

    // Reset values
    chk("rst_bwrite", 32'(bwrite), 32'h0);
    chk("rst_bsize", 32'(bsize), 32'h0);
    chk("rst_baddr", baddr, 32'h0);
    chk("rst_bwdata", bwdata, 32'h0);
    cycle();

    // bready_n low while idle is ignored
    rst = 1'b0; bready_n = 1'b0; brdata = 32'h1234_5678;
    repeat (2) cycle();

    // Fetch with completion two cycles after breq rises
    bready_n = 1'b1; ireq = 1'b1; iaddr = 32'h0000_0100;
    cycle();
    chk("fetch_bsize", 32'(bsize), 32'(SZ_WORD));
    cycle();
    cycle();
    bready_n = 1'b0; brdata = 32'h0000_0013;
    cycle();
    chk("fetch_irdata", last_irdata, 32'h0000_0013);
    ireq = 1'b0; bready_n = 1'b1;
    cycle();

    // Simultaneous requests: data store first, fetch after the bubble
    ireq = 1'b1; iaddr = 32'h0000_0200;
    dreq = 1'b1; dwrite = 1'b1; dsize = SZ_WORD; daddr = 32'h0000_2000; dwdata = 32'hDEAD_BEEF;
    cycle();
    chk("simul_d_addr", baddr, 32'h0000_2000);
    chk("simul_d_wdata", bwdata, 32'hDEAD_BEEF);
    bready_n = 1'b0; brdata = 32'h0;
    cycle();
    dreq = 1'b0; dwrite = 1'b0; bready_n = 1'b1;
    cycle();
    chk("simul_i_addr", baddr, 32'h0000_0200);
    bready_n = 1'b0; brdata = 32'hCAFE_0001;
    cycle();
    ireq = 1'b0; bready_n = 1'b1;
    cycle();

    // bbusy holds off a pending data request
    dreq = 1'b1; daddr = 32'h0000_0500; dsize = SZ_HALF; bbusy = 1'b1;
    repeat (3) begin
      cycle();
      chk("busy_breq", 32'(breq), 32'h0);
    end
    bbusy = 1'b0;
    cycle();
    chk("busy_grant", 32'(breq), 32'h1);
    bready_n = 1'b0; brdata = 32'h0000_AAAA;
    cycle();
    dreq = 1'b0; bready_n = 1'b1;
    cycle();

    // Reset mid data transaction: no ready pulse, bus dropped
    dreq = 1'b1; daddr = 32'h0000_0600;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rstmid_breq", 32'(breq), 32'h0);
    rst = 1'b0; dreq = 1'b0;
    cycle();

    // Both requesters held continuously with single-cycle bus latency
    ireq = 1'b1; iaddr = 32'h0000_0300;
    dreq = 1'b1; daddr = 32'h0000_0400; dwrite = 1'b0; dsize = SZ_WORD;
    bready_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (breq === 1'b1) seq.push_back(baddr);
    end
    chk("starve_grants", 32'(seq.size()), 32'd10);
    for (int k = 0; k < seq.size(); k++) begin
      chk("starve_order", seq[k], (GUARD && (k % 5 == 4)) ? 32'h0000_0300 : 32'h0000_0400);
    end
    ireq = 1'b0; dreq = 1'b0; bready_n = 1'b1;
    cycle();
    cycle();

    // Randomized traffic
    ipend = 1'b0;
    dpend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!ipend && ($urandom_range(0, 2) == 0)) begin
        ipend = 1'b1;
        iaddr = $urandom;
      end
      if (!dpend && ($urandom_range(0, 2) == 0)) begin
        dpend  = 1'b1;
        daddr  = $urandom;
        dwdata = $urandom;
        dwrite = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       dsize = SZ_BYTE;
          1:       dsize = SZ_HALF;
          default: dsize = SZ_WORD;
        endcase
      end
      ireq     = ipend;
      dreq     = dpend;
      bbusy    = ($urandom_range(0, 3) == 0);
      bready_n = m_busy ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      brdata   = $urandom;
      cycle();
      if (i_done) ipend = 1'b0;
      if (d_done) dpend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
